// File: rtl/scan_pkg.sv
// scan_pkg: shared types and sizes for the LED matrix row scanner.
package scan_pkg;
  localparam int NUM_ROWS = 8;
  localparam int ROW_W = 3;
  localparam int COL_W = 8;
  localparam int DWELL_W = 16;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
  typedef logic [NUM_ROWS-1:0][COL_W-1:0] frame_t;
  // Timer reload value so a dwell of d lasts max(d,1) cycles.
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction
endpackage

// File: rtl/scan_timer.sv
// scan_timer: loadable down counter; done is high while the count sits at zero.
module scan_timer
  import scan_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               done
);
  logic [DWELL_W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/row_scan_ctrl.sv
// row_scan_ctrl: 8x8 matrix row scanner with a double-buffered frame handshake.
// Define ROW_SCAN_BRIGHT_EN to add the bright input for PWM dimming inside each dwell.
module row_scan_ctrl
  import scan_pkg::*;
#(
  parameter int BLANK_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [DWELL_W-1:0]        dwell_cycles,
  input  logic [NUM_ROWS*COL_W-1:0] frame_in,
  input  logic                      frame_valid,
`ifdef ROW_SCAN_BRIGHT_EN
  input  logic [ROW_W-1:0]          bright,
`endif
  output logic                      frame_ready,
  output logic [ROW_W-1:0]          row_sel,
  output logic                      row_en,
  output logic [COL_W-1:0]          col_data,
  output logic                      frame_done
);
  state_t state;
  frame_t active, pending;
  logic done, blank_end, drive_end, wrap, swap, tmr_load;
  logic [DWELL_W-1:0] tmr_val;
`ifdef ROW_SCAN_BRIGHT_EN
  logic [ROW_W-1:0] phase;
`endif
  always_comb begin
    blank_end = state == BLANK && done;
    drive_end = state == DRIVE && done;
    wrap = enable && drive_end && row_sel == ROW_W'(NUM_ROWS - 1);
    swap = !frame_ready && (state == IDLE || wrap);
    tmr_load = enable && (state == IDLE || blank_end || drive_end);
    tmr_val = blank_end ? dwell_load(dwell_cycles) : DWELL_W'(BLANK_CYCLES - 1);
  end
  scan_timer u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .load(tmr_load),
    .load_val(tmr_val),
    .done(done)
  );
  // Column data is latched at DRIVE entry, so a row never mixes two frames.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      row_sel <= '0;
      row_en <= 1'b0;
      col_data <= '0;
      frame_done <= 1'b0;
      frame_ready <= 1'b1;
      active <= '0;
      pending <= '0;
`ifdef ROW_SCAN_BRIGHT_EN
      phase <= '0;
`endif
    end else begin
      frame_done <= wrap;
      if (swap) begin
        active <= pending;
        frame_ready <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        pending <= frame_in;
        frame_ready <= 1'b0;
      end
      if (state == IDLE) state <= enable ? BLANK : IDLE;
      else if (!enable) begin
        state <= IDLE;
        row_sel <= '0;
        row_en <= 1'b0;
        col_data <= '0;
      end else if (blank_end) begin
        state <= DRIVE;
        row_en <= 1'b1;
        col_data <= active[row_sel];
`ifdef ROW_SCAN_BRIGHT_EN
        phase <= '0;
`endif
      end else if (drive_end) begin
        state <= BLANK;
        row_en <= 1'b0;
        col_data <= '0;
        row_sel <= row_sel + 1'b1;
      end
`ifdef ROW_SCAN_BRIGHT_EN
      else if (state == DRIVE) begin
        phase <= phase + 1'b1;
        row_en <= ROW_W'(phase + 1'b1) <= bright;
      end
`endif
    end
endmodule

// File: tb/tb_row_scan_ctrl.sv
// tb_row_scan_ctrl: random stimulus against a row/position based scan model.
module tb_row_scan_ctrl;
  localparam int B = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic [15:0] dwell_cycles = 16'd4;
  logic [63:0] frame_in = '0;
  logic frame_valid = 1'b0;
  logic [2:0] bright = 3'd7;
  logic frame_ready, row_en, frame_done;
  logic [2:0] row_sel;
  logic [7:0] col_data;
  int checks = 0;
  int errors = 0;
  logic [7:0] act[8];
  logic [7:0] pend[8];
  bit m_run, m_ready, m_done;
  int m_row, m_pos, m_dw;
  logic [2:0] m_br;

  row_scan_ctrl #(.BLANK_CYCLES(B)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .dwell_cycles(dwell_cycles),
    .frame_in(frame_in),
    .frame_valid(frame_valid),
`ifdef ROW_SCAN_BRIGHT_EN
    .bright(bright),
`endif
    .frame_ready(frame_ready),
    .row_sel(row_sel),
    .row_en(row_en),
    .col_data(col_data),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_ready = 1; m_done = 0;
    m_row = 0; m_pos = 0; m_dw = 1; m_br = 3'd7;
    for (int r = 0; r < 8; r++) begin
      act[r] = '0;
      pend[r] = '0;
    end
  endtask

  // Within a row: positions 0..B-1 are blanking, B..B+dwell-1 are on-time.
  function automatic logic exp_en();
    if (!m_run || m_pos < B) return 1'b0;
`ifdef ROW_SCAN_BRIGHT_EN
    return (m_pos == B) || (3'((m_pos - B) % 8) <= m_br);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_step(input bit en, input logic [15:0] dw, input bit fv,
                            input logic [63:0] fin, input logic [2:0] br);
    bit eor, wrap, swap;
    eor = m_run && m_pos >= B && m_pos == B + m_dw - 1;
    wrap = en && eor && m_row == 7;
    swap = !m_ready && (!m_run || wrap);
    m_done = wrap;
    if (swap) begin
      for (int r = 0; r < 8; r++) act[r] = pend[r];
      m_ready = 1;
    end else if (fv && m_ready) begin
      for (int r = 0; r < 8; r++) pend[r] = fin[8*r +: 8];
      m_ready = 0;
    end
    m_br = br;
    if (!m_run) begin
      m_run = en; m_row = 0; m_pos = 0;
    end else if (!en) begin
      m_run = 0; m_row = 0; m_pos = 0;
    end else if (eor) begin
      m_row = (m_row + 1) % 8; m_pos = 0;
    end else begin
      if (m_pos == B - 1) m_dw = (dw == 0) ? 1 : int'(dw);
      m_pos++;
    end
  endtask

  task automatic cycle(input bit en, input logic [15:0] dw, input bit fv,
                       input logic [63:0] fin, input logic [2:0] br);
    enable = en; dwell_cycles = dw; frame_valid = fv; frame_in = fin; bright = br;
    model_step(en, dw, fv, fin, br);
    @(negedge clk);
    chk("row_en", row_en, exp_en());
    chk("row_sel", row_sel, m_run ? m_row : 0);
    chk("col_data", col_data, (m_run && m_pos >= B) ? act[m_row] : 8'h00);
    chk("frame_done", frame_done, m_done);
    chk("frame_ready", frame_ready, m_ready);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_row_en"}, row_en, 0);
    chk({tag, "_row_sel"}, row_sel, 0);
    chk({tag, "_col_data"}, col_data, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_ready"}, frame_ready, 1);
  endtask

  initial begin
    logic [15:0] dw;
    logic [2:0] br;
    bit found;
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks("reset");
    reset_n = 1'b1;
    // Frame loaded in IDLE, swapped in IDLE, then scanned with dwell 4.
    cycle(0, 16'd4, 1, 64'h0102040810204080, 3'd7);
    cycle(0, 16'd4, 0, '0, 3'd7);
    cycle(0, 16'd4, 0, '0, 3'd7);
    for (int i = 0; i < 110; i++) cycle(1, 16'd4, i == 20, 64'hA5A5_5A5A_0F0F_F0F0, 3'd7);
    for (int i = 0; i < 30; i++) cycle(1, 16'd0, 0, '0, 3'd7);
    for (int i = 0; i < 60; i++) cycle(1, (i < 9) ? 16'd4 : 16'd9, 0, '0, 3'd7);
`ifdef ROW_SCAN_BRIGHT_EN
    for (int i = 0; i < 200; i++) cycle(1, 16'd16, 0, '0, (i < 100) ? 3'd3 : 3'd7);
`endif
    // Asynchronous reset while a row is being driven.
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      cycle(1, 16'd4, 0, '0, 3'd7);
      found = m_run && m_pos >= B;
    end
    chk("drive_wait", found, 1);
    #1 reset_n = 1'b0;
    #1 reset_checks("async_reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    dw = 16'd3;
    br = 3'd7;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) dw = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) br = 3'($urandom_range(0, 7));
      cycle($urandom_range(0, 99) < 97, dw, $urandom_range(0, 3) == 0,
            {$urandom, $urandom}, br);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/row_scan_ctrl.md
ROW_SCAN_CTRL -- requirements
Module: row_scan_ctrl

Interface
REQ-001 SHALL have parameter BLANK_CYCLES, default 2, row-off cycles between consecutive rows (legal range 1..15).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port enable  input  1  scanning runs while high.
REQ-005 SHALL have port dwell_cycles  input  16  on-time per row in clocks, sampled on entry to DRIVE; 0 treated as 1.
REQ-006 SHALL have port frame_in  input  64  new frame; bits [8r+7:8r] = column data of row r.
REQ-007 SHALL have port frame_valid  input  1  frame_in valid.
REQ-008 SHALL have port frame_ready  output  1  pending buffer empty; frame accepted when valid and ready are both high.
REQ-009 SHALL have port row_sel  output  3  row index to the 3-to-8 row decoder select input.
REQ-010 SHALL have port row_en  output  1  row decoder enable.
REQ-011 SHALL have port col_data  output  8  column data for row_sel.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at the end of row 7 dwell.

Function
REQ-013 SHALL implement states IDLE, BLANK, DRIVE; all outputs registered.
REQ-014 IDLE: row_en=0, row_sel=0; enable high -> BLANK next cycle.
REQ-015 BLANK: row_en=0 for exactly BLANK_CYCLES cycles, then DRIVE.
REQ-016 DRIVE: row_en=1, col_data=active[row_sel], for exactly max(dwell_cycles,1) cycles.
REQ-017 At DRIVE expiry: row_sel increments mod 8, then -> BLANK; at row 7 expiry frame_done pulses once in that cycle and row_sel wraps to 0.
REQ-018 enable low in BLANK or DRIVE -> IDLE next cycle; row_en=0, row_sel=0; partial frame abandoned, no frame_done.
REQ-019 Handshake: frame_valid&&frame_ready captures frame_in into pending buffer; frame_ready drops the following cycle; frame_valid held without ready SHALL be ignored.
REQ-020 Swap pending->active SHALL occur only at row 7 expiry (same cycle as frame_done) or any cycle in IDLE; swap clears pending, frame_ready rises next cycle.
REQ-021 Capture and swap cannot coincide (ready low while pending full); pending empty at a frame boundary -> active frame repeats.
REQ-022 Row r SHALL never be driven with data of two different frames within one dwell.

Reset
REQ-023 reset_n low SHALL immediately force IDLE, row_sel=0, row_en=0, col_data=0, frame_done=0, frame_ready=1, active and pending buffers cleared, timer cleared.
REQ-024 Reset assertion mid-DRIVE SHALL drop row_en without waiting for a clock; release takes effect on next rising edge.

Configuration
REQ-025 Macro ROW_SCAN_BRIGHT_EN defined: input port bright (3 bits) added; a 3-bit phase counter advances each DRIVE cycle, reset to 0 on DRIVE entry; row_en = (phase <= bright) in DRIVE.
REQ-026 Macro undefined: no bright port, no phase counter; row_en=1 throughout DRIVE.

Structure
REQ-027 Package scan_pkg SHALL hold the state enum, NUM_ROWS=8, ROW_W=3, COL_W=8, DWELL_W=16 and the 8x8 frame typedef.
REQ-028 Sub-module scan_timer (loadable 16-bit down counter, load/done) SHALL time both BLANK and DRIVE.

Verification
REQ-029 Reset then enable=1, dwell=4, BLANK=2 -> row_sel 0..7 each with row_en high exactly 4 cycles, 2 low cycles between, frame_done once per 48 cycles.
REQ-030 Load frame 64'h0102040810204080 in IDLE, then enable -> col_data row0=8'h80, row7=8'h01; frame_ready back high one cycle after swap.
REQ-031 Offer frame B at row 3 mid-frame -> rows 3..7 still show frame A; frame B appears at row 0 after frame_done; frame_ready low until that swap.
REQ-032 dwell_cycles=0 -> 1-cycle DRIVE per row; change dwell 4->9 mid-DRIVE -> current row keeps 4, next row 9.
REQ-033 enable low during row 5 DRIVE -> row_en 0 next cycle, IDLE, no frame_done; re-enable restarts at row 0; reset_n pulse mid-DRIVE -> row_en 0 asynchronously, all outputs at reset values.
REQ-034 With ROW_SCAN_BRIGHT_EN, bright=3, dwell=16 -> row_en high 4 of every 8 DRIVE cycles; bright=7 -> always high.
